sdram_responder: RTL

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sdram_responder.sv
// Behavioural SDR SDRAM responder: 4 banks, burst length 1, CAS latency 2 or 3.
// Define SDRAM_RESP_ERR_CHECK_EN to build the sticky protocol checker behind err_flags.
module sdram_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [12:0] sdram_wire_addr,
  input  logic [1:0]  sdram_wire_ba,
  input  logic        sdram_wire_cs_n,
  input  logic        sdram_wire_ras_n,
  input  logic        sdram_wire_cas_n,
  input  logic        sdram_wire_we_n,
  input  logic        sdram_wire_cke,
  input  logic [1:0]  sdram_wire_dqm,
  inout  wire  [15:0] sdram_wire_dq,
  output logic [3:0]  err_flags,
  output logic [15:0] refresh_cnt
);
  // Per-bank state (bit of bank_act):
  // state  | meaning
  // IDLE   | bank precharged; READ/WRITE do not touch the array
  // ACTIVE | open_row holds the latched row; READ/WRITE access the array

  localparam int AW    = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  cmd_e                cmd;
  logic [3:0]          bank_act;
  logic [3:0]          bank_act_nxt;
  logic [ROW_BITS-1:0] open_row     [4];
  logic [ROW_BITS-1:0] open_row_nxt [4];
  logic [15:0]         mem [DEPTH];
  logic [AW-1:0]       idx;
  logic                sel_act;
  logic                is_rd;
  logic                is_wr;
  logic [2:0]          cl;
  logic [2:0]          pv;
  logic [15:0]         pd [3];
  logic [1:0]          pm [3];
  logic                drv_v;
  logic [15:0]         drv_d;
  logic [1:0]          drv_m;

  always_comb begin
    if (sdram_wire_cke && !sdram_wire_cs_n)
      cmd = cmd_e'({sdram_wire_ras_n, sdram_wire_cas_n, sdram_wire_we_n});
    else
      cmd = CMD_NOP;
  end

  assign sel_act = bank_act[sdram_wire_ba];
  assign idx     = {sdram_wire_ba, open_row[sdram_wire_ba], sdram_wire_addr[COL_BITS-1:0]};
  assign is_rd   = (cmd == CMD_RD) && sel_act;
  assign is_wr   = (cmd == CMD_WR) && sel_act;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bank_act <= '0;
      for (int i = 0; i < 4; i++) open_row[i] <= '0;
    end else begin
      bank_act <= bank_act_nxt;
      open_row <= open_row_nxt;
    end
  end

  always_comb begin
    bank_act_nxt = bank_act;
    open_row_nxt = open_row;
    case (cmd)
      CMD_ACT: begin
        bank_act_nxt[sdram_wire_ba] = 1'b1;
        open_row_nxt[sdram_wire_ba] = sdram_wire_addr[ROW_BITS-1:0];
      end
      CMD_PRE: begin
        if (sdram_wire_addr[10]) bank_act_nxt = '0;
        else                     bank_act_nxt[sdram_wire_ba] = 1'b0;
      end
      CMD_RD, CMD_WR: begin
        if (sel_act && sdram_wire_addr[10]) bank_act_nxt[sdram_wire_ba] = 1'b0;
      end
      default: ;
    endcase
  end

  // Array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk_clk) begin
    if (is_wr) begin
      if (!sdram_wire_dqm[0]) mem[idx][7:0]  <= sdram_wire_dq[7:0];
      if (!sdram_wire_dqm[1]) mem[idx][15:8] <= sdram_wire_dq[15:8];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pv <= '0;
      for (int i = 0; i < 3; i++) begin
        pd[i] <= '0;
        pm[i] <= '0;
      end
    end else if (sdram_wire_cke) begin
      pv    <= {pv[1:0], is_rd};
      pd[0] <= mem[idx];
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pm[0] <= sdram_wire_dqm;
      pm[1] <= pm[0];
      pm[2] <= pm[1];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cl          <= 3'd3;
      refresh_cnt <= '0;
    end else begin
      if (cmd == CMD_LMR && (sdram_wire_addr[6:4] == 3'd2 || sdram_wire_addr[6:4] == 3'd3))
        cl <= sdram_wire_addr[6:4];
      if (cmd == CMD_REF && refresh_cnt != 16'hFFFF)
        refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  // Stage CL-1 of the pipe is on the bus during the cycle ending at edge k+CL.
  always_comb begin
    if (cl == 3'd2) begin
      drv_v = pv[1];
      drv_d = pd[1];
      drv_m = pm[1];
    end else begin
      drv_v = pv[2];
      drv_d = pd[2];
      drv_m = pm[2];
    end
  end

  assign sdram_wire_dq[7:0]  = (drv_v && !drv_m[0]) ? drv_d[7:0]  : 8'hzz;
  assign sdram_wire_dq[15:8] = (drv_v && !drv_m[1]) ? drv_d[15:8] : 8'hzz;

`ifdef SDRAM_RESP_ERR_CHECK_EN
  logic [3:0] err_set;

  always_comb begin
    err_set    = '0;
    err_set[0] = (cmd == CMD_RD || cmd == CMD_WR) && !sel_act;
    err_set[1] = (cmd == CMD_ACT) && sel_act;
    err_set[2] = (cmd == CMD_LMR || cmd == CMD_REF) && (|bank_act);
    err_set[3] = (cmd == CMD_WR) && drv_v;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) err_flags <= '0;
    else                err_flags <= err_flags | err_set;
  end
`else
  assign err_flags = '0;
`endif

endmodule
